ofmap_writeback: RTL and testbench

Output-side stage placed directly downstream of `top`. It consumes the `o_ofmap` / `o_ofmap_valid` / `o_done` stream and requantizes each 2×DATA_WIDTH accumulator to DATA_WIDTH with rounding shift, optional ReLU and saturation. It packs LANES results per scratchpad word, buffers packed words in a 4-entry FIFO and writes them to the output SPAD through a ready/valid write port. When the upstream done is seen, it flushes the partial word and signals its own completion.

---
 rtl/ofmap_writeback.sv | 195 +++++++++++++++++++
 tb/tb_ofmap_writeback.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: requantizes the 2*DATA_WIDTH accumulator stream from the
// array, packs LANES results per scratchpad word, buffers packed words in a
// small FIFO and writes them to the output SPAD through a ready/valid port.
// On upstream done the partial word is flushed and o_done pulses once the
// FIFO has drained.
module ofmap_writeback #(
   parameter int DATA_WIDTH      = 8,
   parameter int SPAD_DATA_WIDTH = 64,
   parameter int ADDR_WIDTH      = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        i_clk,
   input  logic                        i_nrst,
   input  logic                        i_reg_clear,
   input  logic                        i_start,
   input  logic [ADDR_WIDTH-1:0]       i_base_addr,
   input  logic [3:0]                  i_shift,
   input  logic                        i_relu_en,
   input  logic [2*DATA_WIDTH-1:0]     i_ofmap,
   input  logic                        i_ofmap_valid,
   input  logic                        i_done,
   output logic [SPAD_DATA_WIDTH-1:0]  o_wr_data,
   output logic [ADDR_WIDTH-1:0]       o_wr_addr,
   output logic                        o_wr_en,
   input  logic                        i_wr_ready,
   output logic [ADDR_WIDTH-1:0]       o_count,
   output logic                        o_overflow,
   output logic                        o_done
);

   localparam int LANES  = SPAD_DATA_WIDTH / DATA_WIDTH;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int ACC_W  = 2*DATA_WIDTH + 1;

   localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_WIDTH-1)) - 1);
   localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

   state_t                     state, state_nxt;
   logic [3:0]                 shift_r;
   logic                       relu_r;
   logic [LANE_W-1:0]          lane_idx;
   logic [DATA_WIDTH-1:0]      lane_regs [LANES];
   logic [ADDR_WIDTH-1:0]      addr_r, count_r;
   logic                       overflow_r;

   logic [SPAD_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]           wr_ptr, rd_ptr;
   logic [CNT_W-1:0]           fifo_cnt;

   logic signed [ACC_W-1:0]    acc_ext, rnd_bias, acc_shr, q_wide;
   logic [DATA_WIDTH-1:0]      q_val;
   logic [SPAD_DATA_WIDTH-1:0] pack_word;

   logic sample_valid, word_full, flush_req, push_req;
   logic fifo_empty, fifo_full, push, pop, drop;

   // Requantize: round-half-up bias, arithmetic shift, optional ReLU, saturate.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update so no latch is inferred.
      acc_ext  = ACC_W'($signed(i_ofmap));
      rnd_bias = '0;
      if (shift_r != 4'd0) rnd_bias = ACC_W'(1) << (shift_r - 4'd1);
      acc_shr  = (acc_ext + rnd_bias) >>> shift_r;
      q_wide   = acc_shr;
      if (relu_r && q_wide[ACC_W-1]) q_wide = '0;
      if (q_wide > Q_MAX)      q_wide = Q_MAX;
      else if (q_wide < Q_MIN) q_wide = Q_MIN;
      q_val = q_wide[DATA_WIDTH-1:0];
   end

   // Assemble the word to push: captured lanes, the current sample, zeros above.
   always_comb begin
      pack_word = '0;
      for (int i = 0; i < LANES; i++) begin
         if (LANE_W'(i) < lane_idx)
            pack_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_regs[i];
         else if (LANE_W'(i) == lane_idx && sample_valid)
            pack_word[i*DATA_WIDTH +: DATA_WIDTH] = q_val;
      end
   end

   assign sample_valid = (state == S_ACTIVE) && i_ofmap_valid;
   assign word_full    = sample_valid && (lane_idx == LANE_W'(LANES-1));
   assign flush_req    = (state == S_ACTIVE) && i_done && !word_full &&
                         (sample_valid || lane_idx != '0);
   assign push_req     = word_full || flush_req;
   assign fifo_empty   = (fifo_cnt == '0);
   assign fifo_full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign pop          = !fifo_empty && i_wr_ready;
   assign push         = push_req && (!fifo_full || pop);
   assign drop         = push_req && fifo_full && !pop;

   assign o_wr_en    = !fifo_empty;
   assign o_wr_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];
   assign o_wr_addr  = addr_r;
   assign o_count    = count_r;
   assign o_overflow = overflow_r;

   // State register.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!i_nrst)          state <= S_IDLE;
      else if (i_reg_clear) state <= S_IDLE;
      else                  state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_start) state_nxt = S_ACTIVE;
         S_ACTIVE: if (i_done)  state_nxt = S_DRAIN;
         S_DRAIN:  if (fifo_empty || (fifo_cnt == CNT_W'(1) && pop)) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      o_done = (state == S_DONE);
   end

   // Run configuration, lane index, write address, transfer count, overflow flag.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         shift_r    <= '0;
         relu_r     <= 1'b0;
         lane_idx   <= '0;
         addr_r     <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else if (i_reg_clear) begin
         shift_r    <= '0;
         relu_r     <= 1'b0;
         lane_idx   <= '0;
         addr_r     <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else if (state == S_IDLE && i_start) begin
         shift_r    <= i_shift;
         relu_r     <= i_relu_en;
         lane_idx   <= '0;
         addr_r     <= i_base_addr;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (word_full || (state == S_ACTIVE && i_done)) lane_idx <= '0;
         else if (sample_valid)                          lane_idx <= lane_idx + 1'b1;
         if (pop) begin
            addr_r  <= addr_r + 1'b1;
            count_r <= count_r + 1'b1;
         end
         if (drop) overflow_r <= 1'b1;
      end
   end

   // Lane capture registers.
   always_ff @(posedge i_clk) begin
      // NOTE: storage arrays are not reset; lanes above lane_idx and FIFO slots outside
      // [rd_ptr, wr_ptr) are never observed, so stale contents cannot leak out.
      if (sample_valid) lane_regs[lane_idx] <= q_val;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (i_reg_clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO storage write.
   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr] <= pack_word;
   end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Testbench for ofmap_writeback: transaction-level reference model (queues of
// quantized lanes and packed words) compared every cycle, plus directed runs
// with hand-computed write data/addresses.
`timescale 1ns/1ps
module tb_ofmap_writeback;

   localparam int DW = 8;
   localparam int SW = 64;
   localparam int AW = 8;
   localparam int FD = 4;
   localparam int LANES = SW / DW;

   logic          i_clk = 1'b0;
   logic          i_nrst;
   logic          i_reg_clear;
   logic          i_start;
   logic [AW-1:0] i_base_addr;
   logic [3:0]    i_shift;
   logic          i_relu_en;
   logic [15:0]   i_ofmap;
   logic          i_ofmap_valid;
   logic          i_done;
   logic [SW-1:0] o_wr_data;
   logic [AW-1:0] o_wr_addr;
   logic          o_wr_en;
   logic          i_wr_ready;
   logic [AW-1:0] o_count;
   logic          o_overflow;
   logic          o_done;

   ofmap_writeback #(
      .DATA_WIDTH(DW), .SPAD_DATA_WIDTH(SW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
   ) dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_start(i_start),
      .i_base_addr(i_base_addr), .i_shift(i_shift), .i_relu_en(i_relu_en),
      .i_ofmap(i_ofmap), .i_ofmap_valid(i_ofmap_valid), .i_done(i_done),
      .o_wr_data(o_wr_data), .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en),
      .i_wr_ready(i_wr_ready), .o_count(o_count), .o_overflow(o_overflow),
      .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_ACTIVE, M_DRAIN, M_DONE} mstate_t;
   mstate_t       m_state;
   logic [SW-1:0] m_fifo [$];
   logic [7:0]    m_pend [$];
   logic [AW-1:0] m_addr, m_count;
   bit            m_ovf;
   int            m_shift;
   bit            m_relu;

   function automatic logic [7:0] quant(input logic [15:0] x, input int sh, input bit relu);
      int v, r;
      v = int'($signed(x));
      if (sh > 0) r = (v + (1 << (sh - 1))) >>> sh;
      else        r = v;
      if (relu && r < 0) r = 0;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return 8'(r);
   endfunction

   function automatic logic [SW-1:0] pack_pending();
      logic [SW-1:0] w;
      w = '0;
      for (int i = 0; i < m_pend.size(); i++) w[i*DW +: DW] = m_pend[i];
      return w;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_fifo.delete();
      m_pend.delete();
      m_addr  = '0;
      m_count = '0;
      m_ovf   = 1'b0;
      m_shift = 0;
      m_relu  = 1'b0;
   endtask

   task automatic model_step();
      mstate_t       cur;
      bit            pop, have;
      logic [SW-1:0] w;
      if (!i_nrst || i_reg_clear) begin
         model_reset();
         return;
      end
      cur  = m_state;
      pop  = (m_fifo.size() > 0) && i_wr_ready;
      have = 1'b0;
      w    = '0;
      case (cur)
         M_IDLE: if (i_start) begin
            m_state = M_ACTIVE;
            m_pend.delete();
            m_addr  = i_base_addr;
            m_count = '0;
            m_ovf   = 1'b0;
            m_shift = int'(i_shift);
            m_relu  = i_relu_en;
         end
         M_ACTIVE: begin
            if (i_ofmap_valid) begin
               m_pend.push_back(quant(i_ofmap, m_shift, m_relu));
               if (m_pend.size() == LANES) begin
                  w = pack_pending(); have = 1'b1; m_pend.delete();
               end
            end
            if (i_done) begin
               if (m_pend.size() > 0) begin
                  w = pack_pending(); have = 1'b1; m_pend.delete();
               end
               m_state = M_DRAIN;
            end
         end
         M_DONE: m_state = M_IDLE;
         default: ;
      endcase
      if (pop) begin
         void'(m_fifo.pop_front());
         m_addr++;
         m_count++;
      end
      if (have) begin
         if (m_fifo.size() == FD) m_ovf = 1'b1;
         else                     m_fifo.push_back(w);
      end
      if (cur == M_DRAIN && m_fifo.size() == 0) m_state = M_DONE;
   endtask

   always @(posedge i_clk or negedge i_nrst) model_step();

   // ---------------- compare / monitor ----------------
   int            done_pulses = 0;
   logic [SW-1:0] log_data [$];
   logic [AW-1:0] log_addr [$];

   task automatic monitor_step();
      if (!i_nrst) return;
      if (o_done) done_pulses++;
      if (o_wr_en && i_wr_ready) begin
         log_data.push_back(o_wr_data);
         log_addr.push_back(o_wr_addr);
      end
      check("cmp_wr_en",   64'(o_wr_en),    64'(m_fifo.size() > 0));
      check("cmp_wr_data", o_wr_data,       (m_fifo.size() > 0) ? m_fifo[0] : 64'd0);
      check("cmp_wr_addr", 64'(o_wr_addr),  64'(m_addr));
      check("cmp_count",   64'(o_count),    64'(m_count));
      check("cmp_ovf",     64'(o_overflow), 64'(m_ovf));
      check("cmp_done",    64'(o_done),     64'(m_state == M_DONE));
   endtask

   always @(negedge i_clk) monitor_step();

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_start(input logic [7:0] base, input logic [3:0] sh, input bit relu);
      i_base_addr = base;
      i_shift     = sh;
      i_relu_en   = relu;
      i_start     = 1'b1;
      cyc();
      i_start     = 1'b0;
   endtask

   task automatic send(input logic [15:0] v);
      i_ofmap       = v;
      i_ofmap_valid = 1'b1;
      cyc();
      i_ofmap_valid = 1'b0;
   endtask

   task automatic finish_run(input string name, input bit rand_ready);
      int p0;
      p0     = done_pulses;
      i_done = 1'b1;
      cyc();
      i_done        = 1'b0;
      i_ofmap_valid = 1'b0;
      for (int k = 0; k < 300 && done_pulses == p0; k++) begin
         if (rand_ready) i_wr_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      i_wr_ready = 1'b1;
      cyc(2);
      check({name, "_done_pulses"}, 64'(done_pulses - p0), 64'd1);
   endtask

   task automatic check_write(input string name, input int idx,
                              input logic [63:0] d, input logic [7:0] a);
      if (idx < log_data.size()) begin
         check({name, "_data"}, log_data[idx], d);
         check({name, "_addr"}, 64'(log_addr[idx]), 64'(a));
      end else begin
         check({name, "_present"}, 64'(log_data.size()), 64'(idx + 1));
      end
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_wr_en"},   64'(o_wr_en),    64'd0);
      check({name, "_wr_data"}, o_wr_data,       64'd0);
      check({name, "_wr_addr"}, 64'(o_wr_addr),  64'd0);
      check({name, "_count"},   64'(o_count),    64'd0);
      check({name, "_ovf"},     64'(o_overflow), 64'd0);
      check({name, "_done"},    64'(o_done),     64'd0);
   endtask

   task automatic clear_log();
      log_data.delete();
      log_addr.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [63:0] w;
      int          p0, n;

      i_nrst = 1'b0; i_reg_clear = 1'b0; i_start = 1'b0; i_base_addr = '0;
      i_shift = '0; i_relu_en = 1'b0; i_ofmap = '0; i_ofmap_valid = 1'b0;
      i_done = 1'b0; i_wr_ready = 1'b1;

      // pin the quantizer model with hand-computed values
      check("pin_round",    64'(quant(16'h0018, 4, 1'b0)), 64'h02);
      check("pin_sat_pos",  64'(quant(16'h7FFF, 4, 1'b0)), 64'h7F);
      check("pin_sat_neg",  64'(quant(16'h8000, 4, 1'b0)), 64'h80);
      check("pin_relu",     64'(quant(16'hFFF0, 0, 1'b1)), 64'h00);
      check("pin_neg_noru", 64'(quant(16'hFFF0, 0, 1'b0)), 64'hF0);

      cyc(2);
      check_reset_vals("reset");
      i_nrst = 1'b1;
      cyc();

      // basic pack with latency check
      clear_log();
      do_start(8'h10, 4'd0, 1'b0);
      for (int v = 1; v <= 16; v++) begin
         send(16'(v));
         if (v == 7) check("latency_before", 64'(o_wr_en), 64'd0);
         if (v == 8) check("latency_after",  64'(o_wr_en), 64'd1);
      end
      finish_run("basic", 1'b0);
      check("basic_nwr", 64'(log_data.size()), 64'd2);
      check_write("basic_w0", 0, 64'h0807060504030201, 8'h10);
      check_write("basic_w1", 1, 64'h100F0E0D0C0B0A09, 8'h11);
      check("basic_count", 64'(o_count), 64'd2);

      // done with nothing pending: DRAIN then DONE
      clear_log();
      do_start(8'h50, 4'd0, 1'b0);
      i_done = 1'b1;
      cyc();
      i_done = 1'b0;
      check("empty_done_t1", 64'(o_done), 64'd0);
      cyc();
      check("empty_done_t2", 64'(o_done), 64'd1);
      cyc();
      check("empty_done_t3", 64'(o_done), 64'd0);
      check("empty_nwr", 64'(log_data.size()), 64'd0);

      // quantize: rounding and saturation
      clear_log();
      do_start(8'h00, 4'd4, 1'b0);
      send(16'h0018); send(16'h7FFF); send(16'h8000);
      finish_run("quant", 1'b0);
      check_write("quant_w0", 0, 64'h0000000000807F02, 8'h00);

      // quantize: relu
      clear_log();
      do_start(8'h00, 4'd0, 1'b1);
      send(16'hFFF0); send(16'h0005);
      finish_run("relu", 1'b0);
      check_write("relu_w0", 0, 64'h0000000000000500, 8'h00);

      // partial flush
      clear_log();
      do_start(8'h20, 4'd0, 1'b0);
      send(16'd5); send(16'd6); send(16'd7);
      finish_run("partial", 1'b0);
      check("partial_nwr", 64'(log_data.size()), 64'd1);
      check_write("partial_w0", 0, 64'h0000000000070605, 8'h20);
      check("partial_count", 64'(o_count), 64'd1);

      // backpressure and overflow
      clear_log();
      i_wr_ready = 1'b0;
      do_start(8'h30, 4'd0, 1'b0);
      for (int v = 1; v <= 40; v++) send(16'(v));
      cyc(2);
      check("bp_ovf", 64'(o_overflow), 64'd1);
      check("bp_wr_en", 64'(o_wr_en), 64'd1);
      check("bp_held_data", o_wr_data, 64'h0807060504030201);
      i_wr_ready = 1'b1;
      finish_run("bp", 1'b0);
      check("bp_nwr", 64'(log_data.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         w = '0;
         for (int l = 0; l < LANES; l++) w[l*8 +: 8] = 8'(8*k + l + 1);
         check_write("bp_w", k, w, 8'(8'h30 + k));
      end
      check("bp_count", 64'(o_count), 64'd4);
      check("bp_ovf_sticky", 64'(o_overflow), 64'd1);

      // address wrap
      clear_log();
      do_start(8'hFF, 4'd0, 1'b0);
      for (int v = 1; v <= 16; v++) send(16'(v));
      finish_run("wrap", 1'b0);
      check_write("wrap_w0", 0, 64'h0807060504030201, 8'hFF);
      check_write("wrap_w1", 1, 64'h100F0E0D0C0B0A09, 8'h00);

      // synchronous clear mid-run
      do_start(8'h60, 4'd0, 1'b0);
      send(16'h21); send(16'h22); send(16'h23);
      i_reg_clear = 1'b1;
      cyc();
      i_reg_clear = 1'b0;
      check_reset_vals("clear");
      p0 = done_pulses;
      i_done = 1'b1;
      cyc();
      i_done = 1'b0;
      cyc(4);
      check("clear_idle_no_done", 64'(done_pulses - p0), 64'd0);
      clear_log();
      do_start(8'h40, 4'd0, 1'b0);
      for (int v = 8'h11; v <= 8'h18; v++) send(16'(v));
      finish_run("fresh", 1'b0);
      check("fresh_nwr", 64'(log_data.size()), 64'd1);
      check_write("fresh_w0", 0, 64'h1817161514131211, 8'h40);

      // asynchronous reset with buffered data
      i_wr_ready = 1'b0;
      do_start(8'h70, 4'd0, 1'b0);
      for (int v = 1; v <= 10; v++) send(16'(v));
      #2 i_nrst = 1'b0;
      #1 check_reset_vals("async_rst");
      cyc();
      i_nrst = 1'b1;
      i_wr_ready = 1'b1;
      clear_log();
      cyc(5);
      check("async_no_write", 64'(log_data.size()), 64'd0);

      // randomized runs against the model
      for (int run = 0; run < 12; run++) begin
         i_wr_ready = 1'b1;
         do_start(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         n = $urandom_range(0, 40);
         for (int j = 0; j < n; j++) begin
            i_ofmap_valid = ($urandom_range(0, 2) != 0);
            i_ofmap       = 16'($urandom);
            i_wr_ready    = ($urandom_range(0, 3) != 0);
            i_start       = ($urandom_range(0, 15) == 0);
            cyc();
         end
         i_start       = 1'b0;
         i_ofmap_valid = 1'($urandom_range(0, 1));
         i_ofmap       = 16'($urandom);
         finish_run("rand", 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
